// File: rtl/run_seq_pkg.sv
// Shared types and constants for the run sequencer: state codes, load sizes
// and the positions of each configuration field in the nibble stream.
package run_seq_pkg;

  typedef enum logic [2:0] {
    ST_CFG   = 3'd0,
    ST_MSG   = 3'd1,
    ST_READY = 3'd2,
    ST_RUN   = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam int CFG_NIBBLES = 13;
  localparam int MSG_LEN     = 256;
  localparam int MSG_AW      = 8;
  localparam int CIDX_W      = 4;

  localparam int IDX_ECI0    = 0;
  localparam int IDX_ECI1    = 1;
  localparam int IDX_ECI2    = 2;
  localparam int IDX_SPB     = 3;
  localparam int IDX_CRF0_HI = 4;
  localparam int IDX_CRF0_LO = 5;
  localparam int IDX_EXP0    = 6;
  localparam int IDX_CRF1_HI = 7;
  localparam int IDX_CRF1_LO = 8;
  localparam int IDX_EXP1    = 9;
  localparam int IDX_CRF2_HI = 10;
  localparam int IDX_CRF2_LO = 11;
  localparam int IDX_EXP2    = 12;

endpackage

// File: rtl/run_sequencer_sync.sv
// Two-flop synchronizer for a W-bit asynchronous input; rise_o pulses for one
// cycle when the AND of all synchronized bits goes from 0 to 1.
module sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] async_i,
  output logic         rise_o
);

  logic [W-1:0] meta_q, sync_q;
  logic         level_d, prev_q;

  always_comb level_d = &sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= level_d;
    end
  end

  assign rise_o = level_d & ~prev_q;

endmodule

// File: rtl/run_sequencer.sv
// Board front end: collects strobed nibbles into the configuration fields and
// message memory, then launches one datapath run per start press.
module run_sequencer
  import run_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        Y,
  input  logic              rot_a,
  input  logic              rot_b,
  input  logic              PB1,
  input  logic              run_done,
  output logic [11:0]       eci,
  output logic [3:0]        sndr_probe_blocks,
  output logic [7:0]        crf_blocks0,
  output logic [7:0]        crf_blocks1,
  output logic [7:0]        crf_blocks2,
  output logic [3:0]        exp0,
  output logic [3:0]        exp1,
  output logic [3:0]        exp2,
  output logic              msg_we,
  output logic [MSG_AW-1:0] msg_addr,
  output logic [3:0]        msg_data,
  output logic              cfg_valid,
  output logic              start,
  output logic              busy,
  output logic [7:0]        led
);

  logic              strobe, press;
  logic [3:0]        y_meta_q, y_sync_q;
  state_e            state_q, state_d;
  logic [3:0]        cfg_nib_q [CFG_NIBBLES];
  logic [3:0]        cfg_nib_d [CFG_NIBBLES];
  logic [CIDX_W-1:0] cfg_idx_q, cfg_idx_d;
  logic [MSG_AW-1:0] msg_idx_q, msg_idx_d;
  logic              msg_we_q, msg_we_d;
  logic [MSG_AW-1:0] msg_addr_q, msg_addr_d;
  logic [3:0]        msg_data_q, msg_data_d;
  logic              start_q, start_d;
  logic              cfg_valid_q, cfg_valid_d;
  logic [3:0]        last_nib_q, last_nib_d;

  // A strobe needs both rotary contacts closed, each synchronized on its own.
  sync_edge #(.W(2)) u_rot_edge (
    .clk     (clk),
    .rst     (rst),
    .async_i ({rot_a, rot_b}),
    .rise_o  (strobe)
  );

  sync_edge #(.W(1)) u_pb_edge (
    .clk     (clk),
    .rst     (rst),
    .async_i (PB1),
    .rise_o  (press)
  );

  always_comb begin
    state_d     = state_q;
    cfg_nib_d   = cfg_nib_q;
    cfg_idx_d   = cfg_idx_q;
    msg_idx_d   = msg_idx_q;
    msg_we_d    = 1'b0;
    msg_addr_d  = msg_addr_q;
    msg_data_d  = msg_data_q;
    start_d     = 1'b0;
    last_nib_d  = last_nib_q;
    cfg_valid_d = (state_q == ST_READY) || (state_q == ST_RUN) || (state_q == ST_DONE);

    case (state_q)
      ST_CFG: begin
        if (strobe) begin
          cfg_nib_d[cfg_idx_q] = y_sync_q;
          last_nib_d           = y_sync_q;
          cfg_idx_d            = cfg_idx_q + 1'b1;
          if (cfg_idx_q == CIDX_W'(CFG_NIBBLES - 1)) state_d = ST_MSG;
        end
      end
      ST_MSG: begin
        if (strobe) begin
          msg_we_d   = 1'b1;
          msg_addr_d = msg_idx_q;
          msg_data_d = y_sync_q;
          last_nib_d = y_sync_q;
          // Leaving on the last address keeps the index from ever wrapping.
          if (msg_idx_q == MSG_AW'(MSG_LEN - 1)) state_d = ST_READY;
          else                                   msg_idx_d = msg_idx_q + 1'b1;
        end
      end
      ST_READY: begin
        if (press) begin
          start_d = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (run_done) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (press) begin
          cfg_idx_d = '0;
          msg_idx_d = '0;
          state_d   = ST_CFG;
        end
      end
      default: state_d = ST_CFG;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_meta_q    <= '0;
      y_sync_q    <= '0;
      state_q     <= ST_CFG;
      cfg_nib_q   <= '{default: '0};
      cfg_idx_q   <= '0;
      msg_idx_q   <= '0;
      msg_we_q    <= 1'b0;
      msg_addr_q  <= '0;
      msg_data_q  <= '0;
      start_q     <= 1'b0;
      cfg_valid_q <= 1'b0;
      last_nib_q  <= '0;
    end else begin
      y_meta_q    <= Y;
      y_sync_q    <= y_meta_q;
      state_q     <= state_d;
      cfg_nib_q   <= cfg_nib_d;
      cfg_idx_q   <= cfg_idx_d;
      msg_idx_q   <= msg_idx_d;
      msg_we_q    <= msg_we_d;
      msg_addr_q  <= msg_addr_d;
      msg_data_q  <= msg_data_d;
      start_q     <= start_d;
      cfg_valid_q <= cfg_valid_d;
      last_nib_q  <= last_nib_d;
    end
  end

  assign eci               = {cfg_nib_q[IDX_ECI0], cfg_nib_q[IDX_ECI1], cfg_nib_q[IDX_ECI2]};
  assign sndr_probe_blocks = cfg_nib_q[IDX_SPB];
  assign crf_blocks0       = {cfg_nib_q[IDX_CRF0_HI], cfg_nib_q[IDX_CRF0_LO]};
  assign exp0              = cfg_nib_q[IDX_EXP0];
  assign crf_blocks1       = {cfg_nib_q[IDX_CRF1_HI], cfg_nib_q[IDX_CRF1_LO]};
  assign exp1              = cfg_nib_q[IDX_EXP1];
  assign crf_blocks2       = {cfg_nib_q[IDX_CRF2_HI], cfg_nib_q[IDX_CRF2_LO]};
  assign exp2              = cfg_nib_q[IDX_EXP2];
  assign msg_we            = msg_we_q;
  assign msg_addr          = msg_addr_q;
  assign msg_data          = msg_data_q;
  assign cfg_valid         = cfg_valid_q;
  assign start             = start_q;
  assign busy              = (state_q == ST_RUN);
  assign led               = {state_q, 1'b0, last_nib_q};

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: a per-cycle reference model of the load and
// run rules plus literal spot checks at each phase of the experiment flow.
module tb_run_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  Y;
  logic        rot_a, rot_b, PB1, run_done;
  logic [11:0] eci;
  logic [3:0]  sndr_probe_blocks, exp0, exp1, exp2, msg_data;
  logic [7:0]  crf_blocks0, crf_blocks1, crf_blocks2, msg_addr, led;
  logic        msg_we, cfg_valid, start, busy;

  always #5 clk = ~clk;

  run_sequencer dut (
    .clk(clk), .rst(rst), .Y(Y), .rot_a(rot_a), .rot_b(rot_b), .PB1(PB1),
    .run_done(run_done), .eci(eci), .sndr_probe_blocks(sndr_probe_blocks),
    .crf_blocks0(crf_blocks0), .crf_blocks1(crf_blocks1), .crf_blocks2(crf_blocks2),
    .exp0(exp0), .exp1(exp1), .exp2(exp2), .msg_we(msg_we), .msg_addr(msg_addr),
    .msg_data(msg_data), .cfg_valid(cfg_valid), .start(start), .busy(busy), .led(led)
  );

  int n_vec = 0, n_bad = 0, we_cnt = 0, st_cnt = 0;

  // Reference model: a strobe/press takes effect two edges after the input is
  // first sampled high; the flow rules below are applied at that edge.
  int         m_state, m_ci, m_mi;
  logic [3:0] m_nib [13];
  logic       m_we, m_start, m_cfgv;
  logic [7:0] m_addr;
  logic [3:0] m_data, m_last, yh1, yh2;
  logic       rh1, rh2, rh3, ph1, ph2, ph3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_state <= 0; m_ci <= 0; m_mi <= 0;
      for (int i = 0; i < 13; i++) m_nib[i] <= 4'h0;
      m_we <= 1'b0; m_start <= 1'b0; m_cfgv <= 1'b0;
      m_addr <= 8'h0; m_data <= 4'h0; m_last <= 4'h0;
      rh1 <= 1'b0; rh2 <= 1'b0; rh3 <= 1'b0;
      ph1 <= 1'b0; ph2 <= 1'b0; ph3 <= 1'b0;
      yh1 <= 4'h0; yh2 <= 4'h0;
    end else begin
      rh1 <= rot_a & rot_b; rh2 <= rh1; rh3 <= rh2;
      ph1 <= PB1;           ph2 <= ph1; ph3 <= ph2;
      yh1 <= Y;             yh2 <= yh1;
      m_we <= 1'b0; m_start <= 1'b0;
      m_cfgv <= (m_state >= 2);
      case (m_state)
        0: if (rh2 && !rh3) begin
          m_nib[m_ci] <= yh2; m_last <= yh2; m_ci <= m_ci + 1;
          if (m_ci == 12) m_state <= 1;
        end
        1: if (rh2 && !rh3) begin
          m_we <= 1'b1; m_addr <= m_mi[7:0]; m_data <= yh2; m_last <= yh2;
          m_mi <= m_mi + 1;
          if (m_mi == 255) m_state <= 2;
        end
        2: if (ph2 && !ph3) begin m_start <= 1'b1; m_state <= 3; end
        3: if (run_done) m_state <= 4;
        4: if (ph2 && !ph3) begin m_ci <= 0; m_mi <= 0; m_state <= 0; end
        default: m_state <= 0;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic strobe(input logic [3:0] v);
    Y = v; rot_a = 1'b1; rot_b = 1'b1;
    repeat (2) @(negedge clk);
    rot_a = 1'b0; rot_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic press(input int hold);
    PB1 = 1'b1;
    repeat (hold) @(negedge clk);
    PB1 = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  logic [3:0] cfg_tbl [13];
  int we0, st0;

  initial begin
    rst = 1'b1; Y = 4'h0; rot_a = 1'b0; rot_b = 1'b0; PB1 = 1'b0; run_done = 1'b0;
    cfg_tbl = '{4'd0, 4'd0, 4'd8, 4'd2, 4'd1, 4'd0, 4'd1, 4'd1, 4'd2, 4'd2, 4'd0, 4'd0, 4'd0};

    fork
      forever begin
        @(negedge clk);
        chk("eci",       eci,               {m_nib[0], m_nib[1], m_nib[2]});
        chk("spb",       sndr_probe_blocks, m_nib[3]);
        chk("crf0",      crf_blocks0,       {m_nib[4], m_nib[5]});
        chk("exp0",      exp0,              m_nib[6]);
        chk("crf1",      crf_blocks1,       {m_nib[7], m_nib[8]});
        chk("exp1",      exp1,              m_nib[9]);
        chk("crf2",      crf_blocks2,       {m_nib[10], m_nib[11]});
        chk("exp2",      exp2,              m_nib[12]);
        chk("msg_we",    msg_we,            m_we);
        chk("msg_addr",  msg_addr,          m_addr);
        chk("msg_data",  msg_data,          m_data);
        chk("cfg_valid", cfg_valid,         m_cfgv);
        chk("start",     start,             m_start);
        chk("busy",      busy,              m_state == 3);
        chk("led",       led,               {3'(m_state), 1'b0, m_last});
        we_cnt += int'(msg_we);
        st_cnt += int'(start);
      end
    join_none

    repeat (3) @(negedge clk);
    chk("rst_led", led, 8'h00);
    chk("rst_cfgv", cfg_valid, 1'b0);
    chk("rst_addr", msg_addr, 8'h00);
    rst = 1'b0;

    for (int i = 0; i < 13; i++) strobe(cfg_tbl[i]);
    chk("lit_eci", eci, 12'h008);
    chk("lit_spb", sndr_probe_blocks, 4'h2);
    chk("lit_crf0", crf_blocks0, 8'h10);
    chk("lit_exp0", exp0, 4'h1);
    chk("lit_crf1", crf_blocks1, 8'h12);
    chk("lit_exp1", exp1, 4'h2);
    chk("lit_crf2", crf_blocks2, 8'h00);
    chk("lit_exp2", exp2, 4'h0);
    chk("lit_state_msg", led[7:5], 3'd1);

    for (int i = 0; i < 100; i++) strobe(4'hB);
    press(3);
    chk("msg_press_no_start", st_cnt, 0);

    we0 = we_cnt;
    Y = 4'hB; rot_a = 1'b1; rot_b = 1'b1;
    repeat (20) @(negedge clk);
    rot_a = 1'b0; rot_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("hold_one_capture", we_cnt - we0, 1);

    we0 = we_cnt;
    for (int i = 0; i < 4; i++) begin
      Y = 4'hB; rot_a = 1'b1; rot_b = 1'b1;
      @(negedge clk);
      rot_a = 1'b0; rot_b = 1'b0;
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
    chk("b2b_four_captures", we_cnt - we0, 4);

    for (int i = 0; i < 151; i++) strobe(4'hB);
    repeat (2) @(negedge clk);
    chk("lit_we_total", we_cnt, 256);
    chk("lit_cfg_valid", cfg_valid, 1'b1);
    chk("lit_state_ready", led[7:5], 3'd2);

    strobe(4'h5);
    chk("ready_strobe_ignored", we_cnt, 256);

    st0 = st_cnt;
    PB1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("lit_start_3cyc", start, 1'b1);
    chk("lit_busy_with_start", busy, 1'b1);
    PB1 = 1'b0;
    repeat (4) @(negedge clk);
    chk("lit_start_once", st_cnt - st0, 1);
    chk("lit_busy_hold", busy, 1'b1);

    strobe(4'h7);
    chk("run_strobe_no_we", we_cnt, 256);
    chk("run_strobe_no_field", eci, 12'h008);
    press(3);
    chk("run_press_ignored", st_cnt - st0, 1);

    run_done = 1'b1;
    @(negedge clk);
    run_done = 1'b0;
    chk("lit_busy_clear", busy, 1'b0);
    chk("lit_state_done", led[7:5], 3'd4);
    press(3);
    chk("lit_back_to_cfg", led[7:5], 3'd0);
    chk("lit_cfgv_clear", cfg_valid, 1'b0);
    chk("lit_fields_kept", crf_blocks1, 8'h12);

    for (int i = 0; i < 13; i++) strobe(4'(i));
    for (int i = 0; i < 100; i++) strobe(4'h3);
    Y = 4'h3; rot_a = 1'b1; rot_b = 1'b1;
    for (int k = 0; k < 8 && !msg_we; k++) @(negedge clk);
    chk("we_before_reset", msg_we, 1'b1);
    chk("addr_before_reset", msg_addr, 8'd100);
    #2 rst = 1'b1;
    #1;
    chk("async_we", msg_we, 1'b0);
    chk("async_addr", msg_addr, 8'h00);
    chk("async_data", msg_data, 4'h0);
    chk("async_eci", eci, 12'h000);
    chk("async_led", led, 8'h00);
    chk("async_cfgv", cfg_valid, 1'b0);
    rot_a = 1'b0; rot_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    strobe(4'hA);
    chk("reload_eci", eci, 12'hA00);
    chk("reload_led", led, 8'h0A);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/run_sequencer.md
# run_sequencer

Front-end controller for the covert-channel experiment environment: it turns the board's rotary-strobe nibble entry (`Y` + `rot_a`/`rot_b`) into a fixed sequence of configuration fields and a 256-nibble message. It then waits for the `PB1` start press, launches one experiment run on the datapath and tracks it to completion. It sits between the board I/O and the cache/channel datapath inside `environment`, and is the only writer of the datapath's configuration and message memory.

## Interface
- `CFG_NIBBLES`, 13: configuration nibbles per load.
- `MSG_LEN`, 256: message nibbles per load; address width is 8.
- `clk` in 1: system clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `Y` in 4: nibble entry switches, sampled on strobe.
- `rot_a` in 1: rotary A, asynchronous.
- `rot_b` in 1: rotary B, asynchronous.
- `PB1` in 1: start/restart button, asynchronous, held ≥2 `clk` cycles.
- `run_done` in 1: one-cycle pulse from the datapath when a run ends.
- `eci` out 12: ECI field.
- `sndr_probe_blocks` out 4.
- `crf_blocks0`, `crf_blocks1`, `crf_blocks2` out 8 each.
- `exp0`, `exp1`, `exp2` out 4 each.
- `msg_we` out 1: message memory write enable, one-cycle pulse.
- `msg_addr` out 8: message memory write address.
- `msg_data` out 4: message memory write data.
- `cfg_valid` out 1: high while the configuration and message are complete and stable.
- `start` out 1: one-cycle run launch pulse.
- `busy` out 1: high while a run is in flight.
- `led` out 8: status, `{state[2:0], 1'b0, last_nibble[3:0]}`.

## Operation
- Strobe: `rot_a` and `rot_b` each pass a 2-FF synchronizer. A strobe is the rising edge of the synchronized `rot_a & rot_b`. A strobe captures `Y` (also 2-FF synchronized) as one nibble.
- `PB1` is 2-FF synchronized. A press is its rising edge.
- States:
  - CFG (code 0): each strobe writes nibble `cfg_idx` and increments `cfg_idx`. At `cfg_idx`=12 the strobe moves to MSG.
  - MSG (code 1): each strobe pulses `msg_we` with `msg_addr`=`msg_idx` and `msg_data`=nibble, then increments `msg_idx`. The strobe at `msg_idx`=255 moves to READY.
  - READY (code 2): `cfg_valid`=1. A press pulses `start` and moves to RUN. Strobes are ignored.
  - RUN (code 3): `busy`=1 and `cfg_valid`=1. `run_done` moves to DONE. Strobes and presses are ignored.
  - DONE (code 4): `cfg_valid`=1. A press clears `cfg_idx`/`msg_idx` and moves to CFG. Fields keep their old values until overwritten.
- Field map, nibbles entered MSB-first:
  - idx 0-2 → `eci[11:8]`, `[7:4]`, `[3:0]`
  - idx 3 → `sndr_probe_blocks`
  - idx 4-5 → `crf_blocks0[7:4]`, `[3:0]`
  - idx 6 → `exp0`
  - idx 7-8 → `crf_blocks1`
  - idx 9 → `exp1`
  - idx 10-11 → `crf_blocks2`
  - idx 12 → `exp2`
- Presses in CFG/MSG are ignored. `run_done` outside RUN is ignored.
- A strobe and a press in the same cycle are resolved by state; the two never conflict.
- `msg_idx` never wraps. Leaving MSG happens on the 256th write.

## Timing
- Reset values: state CFG; all fields 0; `cfg_idx`=0, `msg_idx`=0; `msg_we`=0, `msg_addr`=0, `msg_data`=0; `cfg_valid`=0, `start`=0, `busy`=0; `led`=0.
- Reset asserted mid-load or mid-run aborts immediately. `start` and `msg_we` drop asynchronously.
- Strobe latency: `rot_a&rot_b` sampled high at edge k → sync stage 2 at k+1 → field/`msg_we` registered at edge k+2. `msg_we` is high for exactly one cycle.
- `rot` must be low ≥2 cycles and high ≥2 cycles per strobe. One low-high-low cycle of 1 clock each also yields exactly one strobe.
- Press to `start`: 3 cycles. `start` is high 1 cycle, and `busy` rises in the same cycle.
- `run_done` at edge k → `busy`=0 after edge k.
- `cfg_valid` rises the cycle after the final message write.
- Holding `rot` high or `PB1` high produces a single event only.

## Structure
- Package `run_seq_pkg` holds:
  - state enum (CFG, MSG, READY, RUN, DONE with codes 0-4)
  - `CFG_NIBBLES` and `MSG_LEN`
  - field index constants `IDX_ECI0`…`IDX_EXP2`
- Sub-module `sync_edge`: 2-FF synchronizer plus rising-edge detector with async reset to 0. Instantiated for `rot_a&rot_b` (after syncing each input) and for `PB1`.

## Test plan
- Config load: nibbles 0,0,8,2,1,0,1,1,2,2,0,0,0 → `eci`=12'h008, `sndr_probe_blocks`=2, `crf_blocks0`=8'h10, `exp0`=1, `crf_blocks1`=8'h12, `exp1`=2, `crf_blocks2`=0, `exp2`=0; state MSG after the 13th strobe.
- Message: 256 strobes with `Y`=4'hB → 256 `msg_we` pulses, addresses 0..255 in order, data B; `cfg_valid`=1 after the last write; `led[7:5]`=2.
- Run handshake: press `PB1` for 30 ns in READY → one `start` pulse 3 cycles later and `busy`=1; `run_done` pulse → DONE, `busy`=0; a second press → CFG, `cfg_valid`=0.
- Ignored events: press during MSG leaves `msg_idx` unchanged and gives no `start`; strobe during RUN causes no `msg_we` and no field change.
- Strobe held high for 20 cycles → exactly one capture. Back-to-back 1-cycle low/high strobes → one capture each.
- Async reset at `msg_idx`=100 → all outputs immediately at reset values; the next load starts at `cfg_idx`=0.
